reg_scan_serializer: RTL and testbench



---
 rtl/reg_scan_pkg.sv | 19 +
 rtl/reg_scan_serializer_snapshot.sv | 44 ++++
 rtl/reg_scan_serializer.sv | 122 ++++++++++++
 tb/tb_reg_scan_serializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reg_scan_pkg.sv
// Shared definitions for the register-file scan serializer:
// state encoding, default sizing constants and the index-width helper.
package reg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } scan_state_e;

  localparam int NUM_REGS_DEF = 3;
  localparam int DATA_W_DEF   = 2;

  // Width needed to address n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_scan_serializer_snapshot.sv
// reg_snapshot: NUM_REGS x DATA_W capture buffer. All entries load together
// on load_i; one entry is read combinationally through an index mux.
module reg_snapshot
  import reg_scan_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDX_W    = idx_w(NUM_REGS_DEF)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic [NUM_REGS*DATA_W-1:0] regs_i,
  input  logic [IDX_W-1:0]           rd_idx_i,
  output logic [DATA_W-1:0]          rd_data_o
);

  logic [DATA_W-1:0] snap_q [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      // Capture entry gi from the flattened bus on load; clear on reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          snap_q[gi] <= '0;
        end else if (load_i) begin
          snap_q[gi] <= regs_i[gi*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

  // Index mux written as a compare chain so an unused index code reads 0.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        rd_data_o = snap_q[i];
      end
    end
  end

endmodule

// File: rtl/reg_scan_serializer.sv
// reg_scan_serializer: snapshots the register file on start and streams the
// entries out over valid/ready, entry 0 first, then pulses done.
// Optional feature macro: REG_SCAN_SUM_EN adds sum_out, the unsigned sum of
// all entries transferred in the most recent scan.
module reg_scan_serializer
  import reg_scan_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int DATA_W   = DATA_W_DEF,
  localparam int IDX_W    = idx_w(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_REGS*DATA_W-1:0] regs_in,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       done
`ifdef REG_SCAN_SUM_EN
  ,
  output logic [DATA_W+IDX_W-1:0]    sum_out
`endif
);

  scan_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              load;
  logic              is_last;
  logic              xfer;
  logic [DATA_W-1:0] snap_data;

  reg_snapshot #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_snapshot (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .regs_i    (regs_in),
    .rd_idx_i  (idx_q),
    .rd_data_o (snap_data)
  );

  assign is_last = (idx_q == IDX_W'(NUM_REGS - 1));
  assign xfer    = (state_q == SEND) && out_ready;

  // State and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: start only matters in IDLE, ready only in SEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = FIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state; payload is forced to 0 when not valid.
  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == SEND);
    out_data  = out_valid ? snap_data : '0;
    out_idx   = out_valid ? idx_q : '0;
    out_last  = out_valid && is_last;
    done      = (state_q == FIN);
  end

`ifdef REG_SCAN_SUM_EN
  localparam int SUM_W = DATA_W + IDX_W;
  logic [SUM_W-1:0] acc_q;

  // Accumulate each transferred entry; cleared when a scan starts, so the
  // total stays visible from done until the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= '0;
    end else if (xfer) begin
      acc_q <= acc_q + SUM_W'(snap_data);
    end
  end

  assign sum_out = acc_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_reg_scan_serializer.sv
// Self-checking bench for reg_scan_serializer: directed scenarios plus
// randomized scans compared against an entry-list reference model.
module tb_reg_scan_serializer;

  localparam int N  = 3;
  localparam int DW = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N*DW-1:0] regs_in;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          done;
`ifdef REG_SCAN_SUM_EN
  logic [DW+IW-1:0] sum_out;
`endif

  int checks = 0;
  int errors = 0;

  reg_scan_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .regs_in   (regs_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done)
`ifdef REG_SCAN_SUM_EN
    ,
    .sum_out   (sum_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"},  int'(out_data), 0);
    check({tag, "_idx"},   int'(out_idx), 0);
    check({tag, "_last"},  int'(out_last), 0);
    check({tag, "_done"},  int'(done), 0);
  endtask

  // One full scan. Model: the stream is the entry list of vals in index
  // order, each entry appearing once ready is seen; done follows the last.
  task automatic run_scan(input logic [N*DW-1:0] vals, input int stall_idx,
                          input int stall_cycles, input bit scramble,
                          input bit hold_start);
    int exp_sum;
    exp_sum = 0;
    check("pre_busy", int'(busy), 0);
    regs_in   = vals;
    start     = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    step();
    start = hold_start;
    if (scramble) regs_in = '1;
    for (int k = 0; k < N; k++) begin
      logic [DW-1:0] e;
      e = vals[k*DW +: DW];
      exp_sum += int'(e);
      if (k == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_data",  int'(out_data), int'(e));
          check("stall_idx",   int'(out_idx), k);
          step();
          if (scramble) regs_in = N*DW'($urandom);
        end
      end
      out_ready = 1'b1;
      check("xfer_valid", int'(out_valid), 1);
      check("xfer_data",  int'(out_data), int'(e));
      check("xfer_idx",   int'(out_idx), k);
      check("xfer_last",  int'(out_last), (k == N-1) ? 1 : 0);
      check("xfer_done",  int'(done), 0);
      check("xfer_busy",  int'(busy), 1);
      $display("xfer idx=%0d data=%0d", out_idx, out_data);
      step();
    end
    out_ready = 1'($urandom_range(0, 1));
    check("fin_done",  int'(done), 1);
    check("fin_valid", int'(out_valid), 0);
    check("fin_busy",  int'(busy), 1);
`ifdef REG_SCAN_SUM_EN
    check("fin_sum", int'(sum_out), exp_sum);
`endif
    step();
    check("idle_done", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(out_valid), 0);
`ifdef REG_SCAN_SUM_EN
    check("idle_sum", int'(sum_out), exp_sum);
`endif
    $display("scan vals=%h sum=%0d done", vals, exp_sum);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    regs_in   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    step();
    check_idle_zero("rst");
`ifdef REG_SCAN_SUM_EN
    check("rst_sum", int'(sum_out), 0);
`endif
    reset = 1'b0;
    step();
    check_idle_zero("post_rst");

    // Basic scan, data {2,1,0}.
    run_scan(6'b10_01_00, -1, 0, 1'b0, 1'b0);
    // Stall on idx 1 for 4 cycles.
    run_scan(6'b10_01_00, 1, 4, 1'b0, 1'b0);
    // regs_in changes mid-scan must not leak into the stream.
    run_scan(6'b10_01_00, 1, 2, 1'b1, 1'b0);
    // All 3s: sum 9.
    run_scan(6'b11_11_11, -1, 0, 1'b0, 1'b0);
    // start held high: back-to-back scans, one per IDLE visit.
    run_scan(6'b01_10_11, -1, 0, 1'b0, 1'b1);
    run_scan(6'b00_11_01, 0, 1, 1'b0, 1'b1);
    start = 1'b0;
    step();
    check("held_stop_busy", int'(busy), 0);

    // Reset while in SEND at idx 1 with a transfer pending.
    regs_in = 6'b11_10_01;
    start   = 1'b1;
    step();
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    check("mid_idx", int'(out_idx), 1);
    reset = 1'b1;
    step();
    check_idle_zero("mid_rst");
`ifdef REG_SCAN_SUM_EN
    check("mid_rst_sum", int'(sum_out), 0);
`endif
    reset = 1'b0;
    step();
    check("mid_rst_nodone", int'(done), 0);
    run_scan(6'b11_10_01, -1, 0, 1'b0, 1'b0);

    // Randomized scans.
    for (int t = 0; t < 20; t++) begin
      int sidx;
      sidx = int'($urandom_range(0, N)) - 1;
      run_scan(N*DW'($urandom), sidx, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'b0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        check("gap_busy", int'(busy), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
